// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : bus owner codes as seen on owner_o
//   StarveW     : width of the data-grant starvation counter
//   WdogW       : width of the watchdog down-counter
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbIBus = 2'd1,
    ArbDBus = 2'd2,
    ArbResp = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnerNone = 2'b00,
    OwnerIf   = 2'b01,
    OwnerMem  = 2'b10
  } owner_e;

  localparam int StarveW = 8;
  localparam int WdogW   = 16;

  // Saturating increment used by the starvation counter.
  function automatic logic [StarveW-1:0] starve_inc(input logic [StarveW-1:0] cnt,
                                                     input logic [StarveW-1:0] limit);
    return (cnt < limit) ? cnt + StarveW'(1) : cnt;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus-cycle watchdog: a loadable down-counter that flags expiry when the
// transaction has been outstanding for TIMEOUT cycles.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : force counter to zero (highest priority)
//   load_i   : load TIMEOUT-1 at the start of a bus cycle
//   en_i     : a bus cycle is outstanding this clock
//   expire_o : combinational, high in the TIMEOUT-th outstanding cycle
module arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [WdogW-1:0] LoadVal = WdogW'(TIMEOUT - 1);

  logic [WdogW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WdogW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count reached while the cycle is still outstanding.
  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory bus between the instruction-fetch
// port and the data port, one outstanding transaction at a time.
//   clk, rst              : clock, asynchronous active-low reset
//   if_*                  : fetch port (level request, one-cycle ack)
//   mem_*                 : data port (level request, one-cycle ack)
//   bus_*                 : registered external bus command / slave response
//   stallreq_o            : combinational pipeline stall request
//   bus_err_o             : one-cycle pulse on watchdog termination
//   owner_o               : 00 none, 01 fetch, 10 data
//
// state   | meaning
// --------+--------------------------------------------------------------
// ArbIdle | bus free; grant evaluated every cycle
// ArbIBus | fetch cycle on the bus, waiting for bus_ack_i or timeout
// ArbDBus | data cycle on the bus, waiting for bus_ack_i or timeout
// ArbResp | owner's ack_o pulses; no grant; returns to ArbIdle
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                stallreq_o,
  output logic                bus_err_o,
  output logic [1:0]          owner_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [SEL_W-1:0]   ArbSelAll = '1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                bus_err_q, bus_err_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  logic wd_load, wd_clear, wd_en, wd_expire;
  logic busy;

  assign busy     = (state_q == ArbIBus) || (state_q == ArbDBus);
  assign wd_en    = busy;
  assign wd_clear = (state_q == ArbResp);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (wd_clear),
    .load_i   (wd_load),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    starve_d    = starve_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    wd_load     = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        if (!if_req_i) begin
          starve_d = '0;
        end
        // Data wins unless fetch has already been passed over STARVE_LIMIT times.
        if (mem_req_i && (!if_req_i || (starve_q < StarveMax))) begin
          state_d     = ArbDBus;
          owner_d     = OwnerMem;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_sel_d   = mem_sel_i;
          wd_load     = 1'b1;
          if (if_req_i) begin
            starve_d = starve_inc(starve_q, StarveMax);
          end
        end else if (if_req_i) begin
          state_d     = ArbIBus;
          owner_d     = OwnerIf;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_sel_d   = ArbSelAll;
          wd_load     = 1'b1;
          starve_d    = '0;
        end
      end

      ArbIBus, ArbDBus: begin
        // An ack arriving together with expiry still completes normally.
        if (bus_ack_i) begin
          state_d   = ArbResp;
          bus_req_d = 1'b0;
          if (state_q == ArbIBus) begin
            if_rdata_d = bus_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            if (!bus_we_q) begin
              mem_rdata_d = bus_rdata_i;
            end
            mem_ack_d = 1'b1;
          end
        end else if (wd_expire) begin
          state_d   = ArbResp;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == ArbIBus) begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end else begin
            mem_rdata_d = '0;
            mem_ack_d   = 1'b1;
          end
        end
      end

      ArbResp: begin
        state_d = ArbIdle;
        owner_d = OwnerNone;
      end

      default: begin
        state_d   = ArbIdle;
        owner_d   = OwnerNone;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ArbIdle;
      owner_q     <= OwnerNone;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_err_o   = bus_err_q;
  assign owner_o     = owner_q;

  // A held request stalls the pipeline until its own ack is on the port.
  assign stallreq_o = (if_req_i && !if_ack_q) || (mem_req_i && !mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [1:0]  owner_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .TIMEOUT      (8),
    .STARVE_LIMIT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_sel_i   (mem_sel_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_sel_o   (bus_sel_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .stallreq_o  (stallreq_o),
    .bus_err_o   (bus_err_o),
    .owner_o     (owner_o)
  );

  typedef struct {
    logic        fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] slave_rdata;
    int          delay;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] exp_own;
    exp_own = v.fetch ? 2'b01 : 2'b10;
    @(negedge clk);
    if (v.fetch) begin
      if_req_i  = 1'b1;
      if_addr_i = v.addr;
    end else begin
      mem_req_i   = 1'b1;
      mem_we_i    = v.we;
      mem_addr_i  = v.addr;
      mem_wdata_i = v.wdata;
      mem_sel_i   = v.sel;
    end
    #1 chk("stall_waiting", {31'b0, stallreq_o}, 32'd1);
    @(negedge clk);
    chk("grant_bus_req", {31'b0, bus_req_o}, 32'd1);
    chk("grant_owner", {30'b0, owner_o}, {30'b0, exp_own});
    chk("grant_addr", bus_addr_o, v.addr);
    chk("grant_we", {31'b0, bus_we_o}, {31'b0, v.we});
    chk("grant_sel", {28'b0, bus_sel_o}, {28'b0, v.exp_sel});
    chk("grant_wdata", bus_wdata_o, v.exp_wdata);
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      chk("hold_bus_req", {31'b0, bus_req_o}, 32'd1);
    end
    bus_ack_i   = 1'b1;
    bus_rdata_i = v.slave_rdata;
    @(negedge clk);
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    chk("resp_if_ack", {31'b0, if_ack_o}, {31'b0, v.fetch});
    chk("resp_mem_ack", {31'b0, mem_ack_o}, {31'b0, !v.fetch});
    chk("resp_err", {31'b0, bus_err_o}, 32'd0);
    chk("resp_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("resp_stall", {31'b0, stallreq_o}, 32'd0);
    chk("resp_rdata", v.fetch ? if_rdata_o : mem_rdata_o, v.exp_rdata);
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    @(negedge clk);
    chk("after_acks", {30'b0, if_ack_o, mem_ack_o}, 32'd0);
    chk("after_owner", {30'b0, owner_o}, 32'd0);
  endtask

  initial begin
    logic [1:0] exp_order[6];
    int w;
    int cnt;

    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
    exp_order[3] = 2'b10; exp_order[4] = 2'b10; exp_order[5] = 2'b01;

    //          fetch we    addr          wdata         sel      slave_rdata   dly exp_sel exp_wdata     exp_rdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'h0,    32'h3401_0020, 1, 4'hF,   32'h0,        32'h3401_0020};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,        4'hF,    32'h1234_5678, 0, 4'hF,   32'h0,        32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 32'hFFFF_FFFF, 2, 4'b0011, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0,    32'hCAFE_F00D, 3, 4'hF,   32'h0,        32'hCAFE_F00D};
    // ack in the 8th outstanding cycle coincides with watchdog expiry: ack wins
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,        4'b1100, 32'h0BAD_CAFE, 7, 4'b1100, 32'h0,       32'h0BAD_CAFE};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0304, 32'h0,        4'b0001, 32'h0000_00A5, 0, 4'b0001, 32'h0,       32'h0000_00A5};

    rst = 1'b0;
    if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0; bus_rdata_i = 0; bus_ack_i = 0;

    repeat (3) @(negedge clk);
    chk("reset_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("reset_owner", {30'b0, owner_o}, 32'd0);
    chk("reset_acks", {29'b0, if_ack_o, mem_ack_o, bus_err_o}, 32'd0);
    chk("reset_rdata", if_rdata_o | mem_rdata_o, 32'd0);
    chk("reset_stall", {31'b0, stallreq_o}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Concurrent requests: data first, then fetch.
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h200; mem_wdata_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011;
    if_req_i = 1; if_addr_i = 32'h108;
    @(negedge clk);
    chk("conc_owner_d", {30'b0, owner_o}, 32'd2);
    chk("conc_addr_d", bus_addr_o, 32'h200);
    chk("conc_wdata_d", bus_wdata_o, 32'hDEAD_BEEF);
    chk("conc_sel_d", {28'b0, bus_sel_o}, 32'h3);
    chk("conc_we_d", {31'b0, bus_we_o}, 32'd1);
    chk("conc_stall_d", {31'b0, stallreq_o}, 32'd1);
    bus_ack_i = 1;
    @(negedge clk);
    bus_ack_i = 0;
    chk("conc_mem_ack", {30'b0, if_ack_o, mem_ack_o}, 32'd1);
    chk("conc_stall_if", {31'b0, stallreq_o}, 32'd1);
    mem_req_i = 0;
    @(negedge clk);
    chk("conc_gap_owner", {30'b0, owner_o}, 32'd0);
    chk("conc_gap_stall", {31'b0, stallreq_o}, 32'd1);
    @(negedge clk);
    chk("conc_owner_i", {30'b0, owner_o}, 32'd1);
    chk("conc_addr_i", bus_addr_o, 32'h108);
    chk("conc_sel_i", {28'b0, bus_sel_o}, 32'hF);
    bus_ack_i = 1; bus_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    bus_ack_i = 0; bus_rdata_i = 0;
    chk("conc_if_ack", {30'b0, if_ack_o, mem_ack_o}, 32'd2);
    chk("conc_if_rdata", if_rdata_o, 32'h1357_9BDF);
    chk("conc_stall_done", {31'b0, stallreq_o}, 32'd0);
    if_req_i = 0;
    @(negedge clk);

    // Starvation: both held continuously -> D,D,I,D,D,I.
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h400; mem_sel_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h500;
    for (int g = 0; g < 6; g++) begin
      w = 0;
      while (!bus_req_o && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("starve_wait", {31'b0, (w < 10)}, 32'd1);
      chk($sformatf("starve_order_%0d", g), {30'b0, owner_o}, {30'b0, exp_order[g]});
      bus_ack_i = 1; bus_rdata_i = 32'h5555_0000 + g;
      @(negedge clk);
      bus_ack_i = 0; bus_rdata_i = 0;
      if (g == 5) begin
        if_req_i = 0; mem_req_i = 0;
      end
    end
    @(negedge clk);

    // Timeout: no slave ack on a data read.
    @(negedge clk);
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h600; mem_sel_i = 4'hF;
    @(negedge clk);
    cnt = 0;
    while (bus_req_o && cnt < 20) begin
      chk("tmo_no_ack_yet", {31'b0, mem_ack_o}, 32'd0);
      cnt++;
      @(negedge clk);
    end
    chk("tmo_cycles", cnt, 32'd8);
    chk("tmo_mem_ack", {31'b0, mem_ack_o}, 32'd1);
    chk("tmo_err", {31'b0, bus_err_o}, 32'd1);
    chk("tmo_rdata", mem_rdata_o, 32'd0);
    mem_req_i = 0;
    @(negedge clk);
    chk("tmo_err_pulse", {30'b0, bus_err_o, mem_ack_o}, 32'd0);

    // Asynchronous reset in the middle of a data cycle.
    @(negedge clk);
    mem_req_i = 1; mem_addr_i = 32'h700;
    @(negedge clk);
    chk("rst_pre_bus_req", {31'b0, bus_req_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_async_owner", {30'b0, owner_o}, 32'd0);
    chk("rst_async_acks", {30'b0, if_ack_o, mem_ack_o}, 32'd0);
    mem_req_i = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after_idle", {28'b0, owner_o, bus_req_o, mem_ack_o | if_ack_o}, 32'd0);
    end

    // Spurious acks in IDLE and in RESP are ignored.
    bus_ack_i = 1; bus_rdata_i = 32'hFFFF_0000;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_ignored", {27'b0, owner_o, bus_req_o, if_ack_o, mem_ack_o}, 32'd0);
    end
    bus_ack_i = 0;
    if_req_i = 1; if_addr_i = 32'h800;
    @(negedge clk);
    chk("late_grant", {30'b0, owner_o}, 32'd1);
    bus_ack_i = 1; bus_rdata_i = 32'h0246_8ACE;
    @(negedge clk);
    chk("late_first_ack", {30'b0, if_ack_o, mem_ack_o}, 32'd2);
    if_req_i = 0;
    @(negedge clk);
    chk("resp_ack_ignored", {27'b0, owner_o, bus_req_o, if_ack_o, mem_ack_o}, 32'd0);
    chk("resp_rdata_kept", if_rdata_o, 32'h0246_8ACE);
    @(negedge clk);
    bus_ack_i = 0;
    chk("resp_ack_no_err", {30'b0, bus_err_o, bus_req_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
